// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: two-digit 7-segment scan multiplexer with anti-ghost
// blanking, plus a frame-aligned view scheduler. The scheduler shows the
// divider-setting view for a fixed number of frames after the divider code
// changes or force_setting is raised.
module display_scan_ctrl #(
   parameter int unsigned SCAN_DIV     = 12000,
   parameter int unsigned BLANK_CYCLES = 16,
   parameter int unsigned HOLD_FRAMES  = 500
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] clk_divide_input,
   input  logic       force_setting,
   input  logic [7:0] H_seg_in,
   input  logic [7:0] L_seg_in,
   output logic       view_cs,
   output logic [7:0] seg_out,
   output logic [1:0] dig_sel,
   output logic       frame_tick
);

   localparam int unsigned CNT_W  = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned HOLD_W = $clog2(HOLD_FRAMES + 1);

   localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0]  SHOW_LAST  = CNT_W'(SCAN_DIV - BLANK_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_INIT  = HOLD_W'(HOLD_FRAMES);
   localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);

   typedef enum logic [1:0] {
      S_BLANK_H,
      S_SHOW_H,
      S_BLANK_L,
      S_SHOW_L
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [7:0]          seg_out_q, seg_out_d;
   logic [1:0]          dig_sel_q, dig_sel_d;
   logic                frame_tick_q, frame_tick_d;
   logic                view_cs_q, view_cs_d;
   logic                pending_q, pending_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [1:0]          div_prev_q, div_prev_d;
   logic                trig;

   // Next-state, next-output and view-scheduler decode. Outputs are decoded
   // from the next state so the output registers line up with state_q.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      unique case (state_q)
         S_BLANK_H: if (cnt_q == BLANK_LAST) begin state_d = S_SHOW_H;  cnt_d = '0; end
         S_SHOW_H:  if (cnt_q == SHOW_LAST)  begin state_d = S_BLANK_L; cnt_d = '0; end
         S_BLANK_L: if (cnt_q == BLANK_LAST) begin state_d = S_SHOW_L;  cnt_d = '0; end
         S_SHOW_L:  if (cnt_q == SHOW_LAST)  begin state_d = S_BLANK_H; cnt_d = '0; end
      endcase

      dig_sel_d = 2'b00;
      seg_out_d = '0;
      unique case (state_d)
         S_SHOW_H: begin dig_sel_d = 2'b01; seg_out_d = H_seg_in; end
         S_SHOW_L: begin dig_sel_d = 2'b10; seg_out_d = L_seg_in; end
         default:  ;
      endcase
      frame_tick_d = (state_d == S_SHOW_L) && (cnt_d == SHOW_LAST);

      // A trigger seen on the frame_tick cycle itself is consumed directly
      // below; pending only carries triggers from earlier in the frame.
      trig       = (clk_divide_input != div_prev_q) | force_setting;
      div_prev_d = clk_divide_input;
      pending_d  = frame_tick_q ? 1'b0 : (pending_q | trig);
      view_cs_d  = view_cs_q;
      hold_d     = hold_q;
      if (frame_tick_q) begin
         if (trig || pending_q) begin
            view_cs_d = 1'b1;
            hold_d    = HOLD_INIT;
         end else if (view_cs_q) begin
            if (hold_q == HOLD_ONE) begin
               view_cs_d = 1'b0;
               hold_d    = '0;
            end else begin
               hold_d = hold_q - 1'b1;
            end
         end
      end
   end

   // State, counters and registered outputs; synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_BLANK_H;
         cnt_q        <= '0;
         seg_out_q    <= '0;
         dig_sel_q    <= 2'b00;
         frame_tick_q <= 1'b0;
         view_cs_q    <= 1'b0;
         pending_q    <= 1'b0;
         hold_q       <= '0;
         div_prev_q   <= clk_divide_input;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         seg_out_q    <= seg_out_d;
         dig_sel_q    <= dig_sel_d;
         frame_tick_q <= frame_tick_d;
         view_cs_q    <= view_cs_d;
         pending_q    <= pending_d;
         hold_q       <= hold_d;
         div_prev_q   <= div_prev_d;
      end
   end

   assign view_cs    = view_cs_q;
   assign seg_out    = seg_out_q;
   assign dig_sel    = dig_sel_q;
   assign frame_tick = frame_tick_q;

endmodule
